// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: loader state encodings and
// default memory geometry shared with the CPU.
package mem_responder_pkg;

    localparam int DEF_ROM_WIDTH = 11;
    localparam int DEF_ROM_ADDR  = 9;
    localparam int DEF_RAM_WIDTH = 11;
    localparam int DEF_RAM_ADDR  = 9;
    localparam int LD_LEN_WIDTH  = 16;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        W_HI,
        W_LO,
        RUN
    } ld_state_e;

    // Big-endian assembly of two loader bytes.
    function automatic logic [LD_LEN_WIDTH-1:0] be16(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU fetch/data ports and the boot-loader byte stream of the memory responder.
// master = CPU + loader side, slave = mem_responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int g_ROM_WIDTH = DEF_ROM_WIDTH,
    parameter int g_ROM_ADDR  = DEF_ROM_ADDR,
    parameter int g_RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int g_RAM_ADDR  = DEF_RAM_ADDR
);

    logic                   i_rom_en;
    logic [g_ROM_ADDR-1:0]  i_rom_addr;
    logic [g_ROM_WIDTH-1:0] o_rom_data;

    logic                   i_ram_en;
    logic                   i_ram_we;
    logic                   i_ram_re;
    logic [g_RAM_ADDR-1:0]  i_ram_addr;
    logic [g_RAM_WIDTH-1:0] i_ram_data;
    logic [g_RAM_WIDTH-1:0] o_ram_data;

    logic                   i_ld_valid;
    logic [7:0]             i_ld_data;
    logic                   o_ld_ready;

    logic                   o_cpu_hold;
    logic                   o_err;

    modport master (
        output i_rom_en, i_rom_addr,
        output i_ram_en, i_ram_we, i_ram_re, i_ram_addr, i_ram_data,
        output i_ld_valid, i_ld_data,
        input  o_rom_data, o_ram_data, o_ld_ready, o_cpu_hold, o_err
    );

    modport slave (
        input  i_rom_en, i_rom_addr,
        input  i_ram_en, i_ram_we, i_ram_re, i_ram_addr, i_ram_data,
        input  i_ld_valid, i_ld_data,
        output o_rom_data, o_ram_data, o_ld_ready, o_cpu_hold, o_err
    );

endinterface

// File: rtl/mem_responder_sp_sync_ram.sv
// Single-port synchronous RAM: registered read, write-first when read and write
// coincide; i_clr forces the read register to zero.
module sp_sync_ram #(
    parameter int g_WIDTH = 11,
    parameter int g_ADDR  = 9
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [g_ADDR-1:0]  i_addr,
    input  logic [g_WIDTH-1:0] i_wdata,
    output logic [g_WIDTH-1:0] o_rdata
);

    logic [g_WIDTH-1:0] mem [2**g_ADDR];

    // NOTE: the array has no reset branch on purpose; contents survive reset and
    // a reset port on memory would block block-RAM inference.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    // NOTE: sequential state is assigned with <= only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            o_rdata <= '0;
        end else if (i_en && i_we) begin
            if (i_re) begin
                o_rdata <= i_wdata;
            end
        end else if (i_en && i_re) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Program/data memory target for the CPU with a byte-stream boot loader that
// fills the program array and holds the CPU in reset until loading completes.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int g_ROM_WIDTH = DEF_ROM_WIDTH,
    parameter int g_ROM_ADDR  = DEF_ROM_ADDR,
    parameter int g_RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int g_RAM_ADDR  = DEF_RAM_ADDR
) (
    input logic           i_clk,
    input logic           i_rst,
    mem_responder_if.slave bus
);

    ld_state_e                 state_q, state_d;
    logic [g_ROM_ADDR:0]       ld_addr_q, ld_addr_d;
    logic [LD_LEN_WIDTH-1:0]   words_left_q, words_left_d;
    logic [7:0]                hi_byte_q, hi_byte_d;
    logic                      err_q, err_d;
    logic                      ld_ready_q;
    logic                      cpu_hold_q;

    logic                      run;
    logic                      accept;
    logic                      ld_write;
    logic [LD_LEN_WIDTH-1:0]   ld_len;
    logic [g_ROM_WIDTH-1:0]    ld_word;

    assign run     = (state_q == RUN);
    assign accept  = bus.i_ld_valid && ld_ready_q && !run;
    assign ld_len  = be16(hi_byte_q, bus.i_ld_data);
    assign ld_word = {hi_byte_q[g_ROM_WIDTH-9:0], bus.i_ld_data};

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ld_addr_d    = ld_addr_q;
        words_left_d = words_left_q;
        hi_byte_d    = hi_byte_q;
        err_d        = err_q;
        ld_write     = 1'b0;

        case (state_q)
            LEN_HI: if (accept) begin
                hi_byte_d = bus.i_ld_data;
                state_d   = LEN_LO;
            end
            LEN_LO: if (accept) begin
                words_left_d = ld_len;
                state_d      = (ld_len == '0) ? RUN : W_HI;
            end
            W_HI: if (accept) begin
                hi_byte_d = bus.i_ld_data;
                state_d   = W_LO;
            end
            W_LO: if (accept) begin
                // The address MSB flags an index past the array; it saturates there.
                if (ld_addr_q[g_ROM_ADDR]) begin
                    err_d = 1'b1;
                end else begin
                    ld_write  = 1'b1;
                    ld_addr_d = ld_addr_q + 1'b1;
                end
                words_left_d = words_left_q - 1'b1;
                state_d      = (words_left_q == LD_LEN_WIDTH'(1)) ? RUN : W_HI;
            end
            RUN:     state_d = RUN;
            default: state_d = LEN_HI;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= LEN_HI;
            ld_addr_q    <= '0;
            words_left_q <= '0;
            hi_byte_q    <= '0;
            err_q        <= 1'b0;
            ld_ready_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            ld_addr_q    <= ld_addr_d;
            words_left_q <= words_left_d;
            hi_byte_q    <= hi_byte_d;
            err_q        <= err_d;
            ld_ready_q   <= !run;
            cpu_hold_q   <= !run;
        end
    end

    assign bus.o_ld_ready = ld_ready_q;
    assign bus.o_cpu_hold = cpu_hold_q;
    assign bus.o_err      = err_q;

    // The program port belongs to the loader until RUN, then to CPU fetches.
    logic                   rom_en;
    logic [g_ROM_ADDR-1:0]  rom_addr;
    logic                   out_clr;

    assign rom_en   = run ? bus.i_rom_en   : ld_write;
    assign rom_addr = run ? bus.i_rom_addr : ld_addr_q[g_ROM_ADDR-1:0];
    assign out_clr  = i_rst || !run;

    sp_sync_ram #(
        .g_WIDTH (g_ROM_WIDTH),
        .g_ADDR  (g_ROM_ADDR)
    ) u_rom (
        .i_clk   (i_clk),
        .i_clr   (out_clr),
        .i_en    (rom_en),
        .i_we    (!run),
        .i_re    (run),
        .i_addr  (rom_addr),
        .i_wdata (ld_word),
        .o_rdata (bus.o_rom_data)
    );

    sp_sync_ram #(
        .g_WIDTH (g_RAM_WIDTH),
        .g_ADDR  (g_RAM_ADDR)
    ) u_ram (
        .i_clk   (i_clk),
        .i_clr   (out_clr),
        .i_en    (run && bus.i_ram_en),
        .i_we    (bus.i_ram_we),
        .i_re    (bus.i_ram_re),
        .i_addr  (bus.i_ram_addr),
        .i_wdata (bus.i_ram_data),
        .o_rdata (bus.o_ram_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: boot loading, fetches, data
// port reads/writes, loader overflow and reset during load.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int RW    = DEF_ROM_WIDTH;
    localparam int RA    = DEF_ROM_ADDR;
    localparam int DW    = DEF_RAM_WIDTH;
    localparam int DA    = DEF_RAM_ADDR;
    localparam int DEPTH = 2**RA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.g_ROM_WIDTH(RW), .g_ROM_ADDR(RA), .g_RAM_WIDTH(DW), .g_RAM_ADDR(DA)) bus();

    mem_responder #(.g_ROM_WIDTH(RW), .g_ROM_ADDR(RA), .g_RAM_WIDTH(DW), .g_RAM_ADDR(DA)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [RW-1:0] rom_model [DEPTH];
    logic [DW-1:0] ram_model [2**DA];
    logic [RW-1:0] rom_q [$];
    logic [DW-1:0] ram_q [$];
    logic [7:0]    stream [$];
    bit            noise = 1'b0;
    logic [RW-1:0] last_rom;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any live request at an edge produces one output compared after it.
    initial begin
        bit r, d;
        forever begin
            @(posedge clk);
            r = bus.i_rom_en && !rst;
            d = bus.i_ram_en && bus.i_ram_re && !rst;
            @(negedge clk);
            if (r) begin
                if (rom_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rom_unexpected_read: no expectation queued at %0t", $time);
                end else check("rom_read", 32'(bus.o_rom_data), 32'(rom_q.pop_front()));
            end
            if (d) begin
                if (ram_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ram_unexpected_read: no expectation queued at %0t", $time);
                end else check("ram_read", 32'(bus.o_ram_data), 32'(ram_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.i_rom_en   = 1'b0;
        bus.i_rom_addr = '0;
        bus.i_ram_en   = 1'b0;
        bus.i_ram_we   = 1'b0;
        bus.i_ram_re   = 1'b0;
        bus.i_ram_addr = '0;
        bus.i_ram_data = '0;
        bus.i_ld_valid = 1'b0;
        bus.i_ld_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    task automatic do_reset();
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ld_ready", 32'(bus.o_ld_ready), 0);
        check("rst_cpu_hold", 32'(bus.o_cpu_hold), 1);
        check("rst_rom_data", 32'(bus.o_rom_data), 0);
        check("rst_ram_data", 32'(bus.o_ram_data), 0);
        check("rst_err",      32'(bus.o_err), 0);
        rst = 1'b0;
    endtask

    // Reference model of a complete load, straight from the stream rules.
    task automatic model_load();
        int n;
        n = int'({stream[0], stream[1]});
        for (int i = 0; i < n; i++) begin
            int w;
            w = int'({stream[2+2*i], stream[3+2*i]}) % (1 << RW);
            if (i < DEPTH) rom_model[i] = RW'(w);
        end
    endtask

    task automatic new_stream(input int n);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
    endtask

    task automatic push_word(input logic [15:0] w);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    task automatic send_bytes(input bit throttle);
        int  i = 0;
        int  cyc = 0;
        bit  rdy;
        while (i < stream.size() && cyc < 5000) begin
            @(negedge clk);
            bus.i_ld_valid = throttle ? (cyc % 2 == 0) : 1'b1;
            bus.i_ld_data  = stream[i];
            if (noise) begin
                bus.i_rom_en   = 1'b1;
                bus.i_rom_addr = RA'($urandom);
                bus.i_ram_en   = 1'b1;
                bus.i_ram_we   = 1'b1;
                bus.i_ram_re   = 1'b1;
                bus.i_ram_addr = DA'(3);
                bus.i_ram_data = DW'(11'h7A5);
                rom_q.push_back('0);
                ram_q.push_back('0);
            end
            rdy = bus.o_ld_ready;
            @(posedge clk);
            if (bus.i_ld_valid && rdy) i++;
            cyc++;
        end
        if (cyc >= 5000) check("load_timeout", 32'(i), 32'(stream.size()));
    endtask

    task automatic finish_load();
        @(negedge clk);
        clear_inputs();
        check("hold_after_last_byte",  32'(bus.o_cpu_hold), 1);
        check("ready_after_last_byte", 32'(bus.o_ld_ready), 1);
        @(negedge clk);
        check("hold_in_run",  32'(bus.o_cpu_hold), 0);
        check("ready_in_run", 32'(bus.o_ld_ready), 0);
    endtask

    task automatic fetch(input int a);
        @(negedge clk);
        clear_inputs();
        bus.i_rom_en   = 1'b1;
        bus.i_rom_addr = RA'(a);
        rom_q.push_back(rom_model[a]);
        last_rom = rom_model[a];
    endtask

    task automatic ram_op(input bit en, input bit we, input bit re, input int a, input logic [DW-1:0] d);
        @(negedge clk);
        clear_inputs();
        bus.i_ram_en   = en;
        bus.i_ram_we   = we;
        bus.i_ram_re   = re;
        bus.i_ram_addr = DA'(a);
        bus.i_ram_data = d;
        if (en && we) begin
            if (re) ram_q.push_back(d);
            ram_model[a] = d;
        end else if (en && re) begin
            ram_q.push_back(ram_model[a]);
        end
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk);

        // Basic load of three words.
        do_reset();
        new_stream(3);
        push_word(16'h07FF); push_word(16'h0123); push_word(16'h0001);
        model_load();
        send_bytes(1'b0);
        finish_load();
        for (int a = 0; a < 3; a++) fetch(a);
        idle(3);
        check("rom_hold", 32'(bus.o_rom_data), 32'(last_rom));
        check("rom0_value", 32'(last_rom == rom_model[2]), 1);

        // Data port: directed write/read, write-first, then random traffic.
        ram_op(1, 1, 0, 5, 11'h2AA);
        ram_op(1, 0, 1, 5, '0);
        ram_op(1, 1, 1, 5, 11'h155);
        idle(2);
        check("ram_hold", 32'(bus.o_ram_data), 32'h155);
        for (int a = 0; a < 16; a++) ram_op(1, 1, 0, a, DW'($urandom));
        for (int k = 0; k < 60; k++)
            ram_op($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                   $urandom_range(0, 15), DW'($urandom));
        idle(2);

        // Empty load with CPU ports driven before RUN: must have no effect.
        do_reset();
        noise = 1'b1;
        new_stream(0);
        send_bytes(1'b0);
        noise = 1'b0;
        finish_load();
        check("n0_err", 32'(bus.o_err), 0);
        for (int a = 0; a < 3; a++) fetch(a);
        ram_op(1, 0, 1, 3, '0);
        idle(2);

        // Overflow: one word more than the program array holds.
        do_reset();
        new_stream(DEPTH + 1);
        for (int i = 0; i <= DEPTH; i++) push_word(16'($urandom));
        model_load();
        send_bytes(1'b0);
        finish_load();
        check("ovf_err", 32'(bus.o_err), 1);
        fetch(0); fetch(1); fetch(DEPTH - 1);
        for (int k = 0; k < 8; k++) fetch($urandom_range(0, DEPTH - 1));
        idle(10);
        check("ovf_err_sticky", 32'(bus.o_err), 1);
        do_reset();
        @(negedge clk);
        check("err_cleared", 32'(bus.o_err), 0);

        // Throttled loader reproduces the basic load exactly.
        do_reset();
        new_stream(3);
        push_word(16'h07FF); push_word(16'h0123); push_word(16'h0001);
        model_load();
        send_bytes(1'b1);
        finish_load();
        for (int a = 0; a < 3; a++) fetch(a);
        idle(2);

        // Reset after one word: kept word survives, then a normal reload.
        do_reset();
        new_stream(3);
        push_word(16'h055A); push_word(16'h0000);
        stream.pop_back(); stream.pop_back();
        rom_model[0] = 11'h55A;
        send_bytes(1'b0);
        idle(1);
        check("partial_hold", 32'(bus.o_cpu_hold), 1);
        do_reset();
        @(negedge clk);
        check("reload_ready", 32'(bus.o_ld_ready), 1);
        check("reload_hold",  32'(bus.o_cpu_hold), 1);
        new_stream(0);
        send_bytes(1'b0);
        finish_load();
        fetch(0);
        idle(2);
        do_reset();
        new_stream(3);
        push_word(16'h0321); push_word(16'h0654); push_word(16'h0787);
        model_load();
        send_bytes(1'b0);
        finish_load();
        for (int a = 0; a < 3; a++) fetch(a);
        idle(3);

        check("rom_queue_drained", 32'(rom_q.size()), 0);
        check("ram_queue_drained", 32'(ram_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
